// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the elastic MEM/WB pipeline stage.
//   B_DEF, RA_W_DEF  : default data / register-address widths
//   REG_ZERO         : index of the hardwired $zero register
//   mem_wb_payload_t : canonical MEM/WB payload at the default widths
//   payload_width()  : flat payload width for arbitrary B / RA_W
package mem_wb_stage_pkg;

   localparam int unsigned B_DEF    = 32;
   localparam int unsigned RA_W_DEF = 5;
   localparam int unsigned REG_ZERO = 0;

   typedef struct packed {
      logic [B_DEF-1:0]    read_data;
      logic [B_DEF-1:0]    alu_result;
      logic [RA_W_DEF-1:0] write_reg;
      logic                regwrite;
      logic                memtoreg;
   } mem_wb_payload_t;

   // Flat layout used by the slots: {read_data, alu_result, write_reg, regwrite, memtoreg}
   function automatic int unsigned payload_width(input int unsigned b, input int unsigned ra_w);
      return 2 * b + ra_w + 2;
   endfunction

endpackage

// File: rtl/mem_wb_stage_pipe_slot.sv
// One pipeline slot: a payload register plus its valid bit.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and payload)
//   load       : capture d and set valid (wins over clear)
//   clear      : drop valid; payload keeps its stale value
//   d / q      : payload in / held payload
//   valid      : slot holds an entry
module pipe_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB stage: valid/ready handshake, optional 2-entry skid buffer, flush,
// $zero write suppression and the MemtoReg writeback mux.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous discard of all held entries and same-cycle input
//   in_valid / in_ready  : MEM-side handshake
//   *_in                 : payload from MEM (read data, ALU result, dest reg, controls)
//   out_valid / out_ready: WB-side handshake
//   *_out                : head payload, qualified regwrite, resolved writeback word
//   occupancy            : number of held entries
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned B    = B_DEF,
   parameter int unsigned RA_W = RA_W_DEF,
   parameter bit          SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [B-1:0]    read_data_in,
   input  logic [B-1:0]    alu_result_in,
   input  logic [RA_W-1:0] write_reg_in,
   input  logic            regwrite_in,
   input  logic            memtoreg_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [B-1:0]    read_data_out,
   output logic [B-1:0]    alu_result_out,
   output logic [RA_W-1:0] write_reg_out,
   output logic            regwrite_out,
   output logic            memtoreg_out,
   output logic [B-1:0]    wb_data_out,
   output logic [1:0]      occupancy
);

   localparam int unsigned PW = payload_width(B, RA_W);

   logic [PW-1:0] in_word;
   logic [PW-1:0] head_d, head_q, skid_q;
   logic          head_valid, skid_valid;
   logic          head_load, head_clear;
   logic          head_regwrite;
   logic          accept, drain;

   assign in_word = {read_data_in, alu_result_in, write_reg_in, regwrite_in, memtoreg_in};

   // Flush discards the offered input, so it never counts as accepted internally.
   assign accept = in_valid & in_ready & ~flush;
   assign drain  = head_valid & out_ready;

   pipe_slot #(.W(PW)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (head_load),
      .clear (head_clear),
      .d     (head_d),
      .q     (head_q),
      .valid (head_valid)
   );

   if (SKID) begin : g_skid
      logic skid_load, skid_clear;

      // in_ready is the registered skid valid bit, so no combinational path from out_ready.
      assign in_ready = ~skid_valid;

      always_comb begin
         head_load  = 1'b0;
         head_d     = in_word;
         skid_load  = 1'b0;
         skid_clear = flush;
         if (!flush) begin
            if (drain && skid_valid) begin
               // in_ready is low here, so no accept can collide with the refill.
               head_load  = 1'b1;
               head_d     = skid_q;
               skid_clear = 1'b1;
            end else if (accept) begin
               if (!head_valid || drain) head_load = 1'b1;
               else                      skid_load = 1'b1;
            end
         end
         head_clear = flush | (drain & ~head_load);
      end

      pipe_slot #(.W(PW)) u_skid (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (in_word),
         .q     (skid_q),
         .valid (skid_valid)
      );
   end else begin : g_no_skid
      assign in_ready   = ~head_valid | out_ready;
      assign skid_valid = 1'b0;
      assign skid_q     = '0;

      always_comb begin
         head_d     = in_word;
         head_load  = accept;
         head_clear = flush | (drain & ~accept);
      end
   end

   assign {read_data_out, alu_result_out, write_reg_out, head_regwrite, memtoreg_out} = head_q;

   assign out_valid    = head_valid;
   assign regwrite_out = head_valid & head_regwrite & (write_reg_out != RA_W'(REG_ZERO));
   assign wb_data_out  = memtoreg_out ? read_data_out : alu_result_out;
   assign occupancy    = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Elastic MEM/WB pipeline stage for the 5-stage MIPS datapath, replacing the free-running MEM/WB latch. It carries load data, ALU result, destination register and writeback control from MEM to WB with a valid/ready handshake, a 2-entry skid buffer, flush, and asynchronous reset. It also performs the MemtoReg writeback selection, so WB and the forwarding unit see one resolved writeback word.

## Interface
- B, 32, data width of read data, ALU result and writeback word
- RA_W, 5, register-address width
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all held entries and any same-cycle input
- in_valid  in  1  MEM presents a valid entry
- in_ready  out  1  stage accepts an entry this cycle
- read_data_in  in  B  data-memory read word
- alu_result_in  in  B  ALU result / address
- write_reg_in  in  RA_W  destination register (RegDst mux output)
- regwrite_in  in  1  RegWrite control
- memtoreg_in  in  1  MemtoReg control
- out_valid  out  1  head entry valid toward WB
- out_ready  in  1  WB consumes head entry
- read_data_out  out  B  head read data
- alu_result_out  out  B  head ALU result
- write_reg_out  out  RA_W  head destination register
- regwrite_out  out  1  qualified register-file write enable
- memtoreg_out  out  1  head MemtoReg
- wb_data_out  out  B  memtoreg_out ? read_data_out : alu_result_out
- occupancy  out  2  entries held (0..2; at most 1 when SKID=0)

## Operation
- Storage: head slot (drives outputs) and, when SKID=1, skid slot; each holds all payload fields plus a valid bit.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- SKID=1: in_ready = !skid_valid, a pure register output.
  - Accept with head empty, or head draining and skid empty: load head.
  - Accept with head held and not draining: load skid.
  - Drain with skid valid: skid moves to head. A simultaneous accept is impossible because in_ready=0.
- SKID=0: in_ready = !head_valid | out_ready. Accept loads head; drain without accept clears head valid.
- Qualification: regwrite_out = head_valid & regwrite & (write_reg != 0). Writes to $zero are suppressed here.
- out_valid = head_valid. Payload outputs hold their last value when invalid and are not zeroed.
- wb_data_out is combinational from the head slot.
- Flush: on the next edge both valid bits clear and occupancy becomes 0. An input offered in the flush cycle is discarded even if in_ready=1. Flush has priority over accept and drain. Payload registers may keep stale values.
- Reset (rst_n=0, immediate):
  - All valid bits and payload registers clear to 0.
  - out_valid=0, regwrite_out=0, memtoreg_out=0.
  - All data outputs read 0, occupancy=0, in_ready=1.

## Timing
- Latency: an entry accepted at edge N is on the outputs after edge N, valid in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1, in both SKID modes.
- Backpressure, SKID=1: out_ready low for k cycles with continuous input fills head and then skid. in_ready drops the cycle after skid fills, and no entry is lost.
- in_ready rises the cycle after the first drain that frees the skid.
- Release of rst_n is synchronised by the caller. The first accept can occur at the first edge after deassertion.
- Reset asserted mid-transfer drops all entries, with no partial state.

## Structure
- Shared package: B, RA_W defaults, REG_ZERO constant (0), and a struct/bundle type for the MEM/WB payload (read_data, alu_result, write_reg, regwrite, memtoreg).
- Sub-module `pipe_slot`: one payload register plus valid bit, async reset, with load/clear controls. Instantiated once as head and once, under SKID, as skid.
- Occupancy is derived from the two valid bits. No separate counter.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: out_valid=0, regwrite_out=0, wb_data_out=0, in_ready=1, occupancy=0. Release, accept alu_result_in=0x1234, memtoreg_in=0. Required next cycle: wb_data_out=0x1234.
- Streaming with out_ready=1: send 8 entries back to back. Required: each appears exactly 1 cycle later, in order, occupancy constant at 1.
- Backpressure (SKID=1): out_ready=0 for 3 cycles with continuous in_valid, entries A,B,C. Required: A in head, B in skid, in_ready=0 from cycle 3, C held upstream. Raise out_ready. Required: A,B,C delivered in order, no loss or duplication.
- Zero-register suppression: write_reg_in=0 with regwrite_in=1. Required: regwrite_out=0. Repeat with write_reg_in=5. Required: regwrite_out=1.
- Flush: with occupancy=2, assert flush together with in_valid=1, data 0xDEAD. Required: next cycle occupancy=0, out_valid=0, 0xDEAD never appears.
- Mid-operation async reset: drop rst_n between edges with occupancy=2. Required: out_valid and regwrite_out fall immediately, before the next clock edge.
